l2_adder_sequencer: RTL and testbench

Controller that sequences the level-2 adder array for the convolution datapath. It collects pairs of packed lane vectors from an upstream valid/ready stream and drives the array's `enable` and operand buses for one cycle per pair. It waits out the array's registered latency, captures the widened per-lane sums and presents them downstream under valid/ready. It runs a programmable number of pairs per job, with start/busy/done control.

---
 rtl/l2_adder_sequencer_if.sv | 37 +++
 rtl/l2_adder_sequencer.sv | 109 ++++++++++
 tb/tb_l2_adder_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_adder_sequencer_if.sv
// Port bundle between l2_adder_sequencer and its surroundings: job control,
// the upstream operand stream, the adder array bus and the downstream result stream.
interface l2_adder_sequencer_if #(
   parameter int DATA_WIDTH = 17,
   parameter int ARRAY_SIZE = 4
);
   localparam int VEC_W = DATA_WIDTH * ARRAY_SIZE;
   localparam int SUM_W = (DATA_WIDTH + 1) * ARRAY_SIZE;

   logic             start;
   logic [7:0]       num_pairs;
   logic             busy;
   logic             done;
   logic             in_valid;
   logic             in_ready;
   logic [VEC_W-1:0] in_data;
   logic             add_enable;
   logic [VEC_W-1:0] add_num_1;
   logic [VEC_W-1:0] add_num_2;
   logic [SUM_W-1:0] add_result;
   logic             out_valid;
   logic             out_ready;
   logic [SUM_W-1:0] out_data;
   logic             out_last;

   modport slave (
      input  start, num_pairs, in_valid, in_data, add_result, out_ready,
      output busy, done, in_ready, add_enable, add_num_1, add_num_2,
             out_valid, out_data, out_last
   );

   modport master (
      output start, num_pairs, in_valid, in_data, add_result, out_ready,
      input  busy, done, in_ready, add_enable, add_num_1, add_num_2,
             out_valid, out_data, out_last
   );
endinterface

// File: rtl/l2_adder_sequencer.sv
// Collects operand pairs, fires the level-2 adder array once per pair, waits out
// its latency and hands the widened lane sums downstream; counts pairs per job.
module l2_adder_sequencer #(
   parameter int DATA_WIDTH  = 17,
   parameter int ARRAY_SIZE  = 4,
   parameter int ADD_LATENCY = 1
) (
   input logic                 clk,
   input logic                 reset,
   l2_adder_sequencer_if.slave bus
);
   localparam int VEC_W = DATA_WIDTH * ARRAY_SIZE;
   localparam int SUM_W = (DATA_WIDTH + 1) * ARRAY_SIZE;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_A, S_LOAD_B, S_ADD, S_WAIT, S_OUT
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [VEC_W-1:0] a_reg;
   logic [VEC_W-1:0] b_reg;
   logic [SUM_W-1:0] out_reg;
   logic [7:0]       remaining;
   logic [2:0]       wait_cnt;
   logic             done_reg;
   logic             last_pair;
   logic             wait_over;
   logic             in_ready;
   logic             add_enable;
   logic             out_valid;
   logic             out_last;
   logic             busy;

   assign last_pair = (remaining == 8'd1);
   // The counter still reads 1 on the edge that ends the final WAIT cycle.
   assign wait_over = (wait_cnt == 3'd1);

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (bus.start && bus.num_pairs != 8'd0) next_state = S_LOAD_A;
         S_LOAD_A: if (bus.in_valid) next_state = S_LOAD_B;
         S_LOAD_B: if (bus.in_valid) next_state = S_ADD;
         S_ADD:    next_state = S_WAIT;
         S_WAIT:   if (wait_over) next_state = S_OUT;
         S_OUT:    if (bus.out_ready) next_state = last_pair ? S_IDLE : S_LOAD_A;
         default:  next_state = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready   = (state == S_LOAD_A) || (state == S_LOAD_B);
      add_enable = (state == S_ADD);
      out_valid  = (state == S_OUT);
      out_last   = (state == S_OUT) && last_pair;
      busy       = (state != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         a_reg     <= '0;
         b_reg     <= '0;
         out_reg   <= '0;
         remaining <= '0;
         wait_cnt  <= '0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.num_pairs == 8'd0) done_reg  <= 1'b1;
                  else                       remaining <= bus.num_pairs;
               end
            end
            S_LOAD_A: if (bus.in_valid) a_reg <= bus.in_data;
            S_LOAD_B: if (bus.in_valid) b_reg <= bus.in_data;
            S_ADD:    wait_cnt <= 3'(ADD_LATENCY);
            S_WAIT: begin
               wait_cnt <= wait_cnt - 3'd1;
               if (wait_over) out_reg <= bus.add_result;
            end
            S_OUT: begin
               if (bus.out_ready) begin
                  remaining <= remaining - 8'd1;
                  if (last_pair) done_reg <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = busy;
   assign bus.done       = done_reg;
   assign bus.in_ready   = in_ready;
   assign bus.add_enable = add_enable;
   assign bus.add_num_1  = a_reg;
   assign bus.add_num_2  = b_reg;
   assign bus.out_valid  = out_valid;
   assign bus.out_data   = out_reg;
   assign bus.out_last   = out_last;
endmodule

// File: tb/tb_l2_adder_sequencer.sv
// Bench for l2_adder_sequencer: models the adder array with its latency and
// checks every result, flag and timing point against a queue-based reference.
module tb_l2_adder_sequencer;
   localparam int DW      = 17;
   localparam int LANES   = 4;
   localparam int ADD_LAT = 1;
   localparam int VEC_W   = DW * LANES;
   localparam int SUM_W   = (DW + 1) * LANES;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   int   n_enable = 0;
   logic [VEC_W-1:0] stim[$];
   logic [SUM_W-1:0] last_out;

   always #5 clk = ~clk;

   l2_adder_sequencer_if #(.DATA_WIDTH(DW), .ARRAY_SIZE(LANES)) bus ();

   l2_adder_sequencer #(
      .DATA_WIDTH(DW), .ARRAY_SIZE(LANES), .ADD_LATENCY(ADD_LAT)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   function automatic logic [SUM_W-1:0] lanes_sum(input logic [VEC_W-1:0] a,
                                                  input logic [VEC_W-1:0] b);
      logic [SUM_W-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++)
         r[i*(DW+1) +: DW+1] = {1'b0, a[i*DW +: DW]} + {1'b0, b[i*DW +: DW]};
      return r;
   endfunction

   function automatic logic [VEC_W-1:0] mk_vec(input int l0, input int l1,
                                               input int l2, input int l3);
      logic [VEC_W-1:0] v;
      v = '0;
      v[0*DW +: DW] = DW'(l0);
      v[1*DW +: DW] = DW'(l1);
      v[2*DW +: DW] = DW'(l2);
      v[3*DW +: DW] = DW'(l3);
      return v;
   endfunction

   // Adder array stand-in: result is only meaningful ADD_LAT edges after enable.
   logic [SUM_W-1:0] pipe_d[ADD_LAT];
   logic             pipe_v[ADD_LAT];
   logic [SUM_W-1:0] junk;
   always @(posedge clk) begin
      pipe_d[0] <= lanes_sum(bus.add_num_1, bus.add_num_2);
      pipe_v[0] <= bus.add_enable;
      for (int i = 1; i < ADD_LAT; i++) begin
         pipe_d[i] <= pipe_d[i-1];
         pipe_v[i] <= pipe_v[i-1];
      end
      junk <= SUM_W'({$urandom, $urandom, $urandom});
      if (reset && bus.add_enable) n_enable <= n_enable + 1;
   end
   assign bus.add_result = pipe_v[ADD_LAT-1] ? pipe_d[ADD_LAT-1] : junk;

   task automatic chk_i(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_v(input string tag, input logic [SUM_W-1:0] obs,
                        input logic [SUM_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one job over the pairs held in stim; checks results, flags and timing.
   task automatic run_job(input int n, input bit toggle_in, input int stall_pair,
                          input int stall_len, input bit poke_start);
      logic [SUM_W-1:0] exp_q[$];
      logic [SUM_W-1:0] held;
      int  idx = 0, res = 0, cyc = 0, added = 0, en0;
      int  stall_left = stall_len, first_hs = -1, first_ov = -1, last_rise = -1;
      bit  prev_ov = 1'b0, prev_stall = 1'b0, hs, ov_hs;
      bit  timing = !toggle_in && (stall_len == 0);
      for (int k = 0; k < n; k++) exp_q.push_back(lanes_sum(stim[2*k], stim[2*k+1]));
      en0 = n_enable;
      held = '0;
      bus.start     = 1'b1;
      bus.num_pairs = 8'(n);
      tick();
      bus.start = 1'b0;
      bus.num_pairs = 8'($urandom_range(0, 255));
      chk_i("busy_after_start", int'(bus.busy), 1);
      while (res < n && cyc < 400) begin
         chk_i("done_early", int'(bus.done), 0);
         if (poke_start) bus.start = (cyc == 2);
         if (bus.add_enable) begin
            chk_v("add_num_1", SUM_W'(bus.add_num_1), SUM_W'(stim[2*added]));
            chk_v("add_num_2", SUM_W'(bus.add_num_2), SUM_W'(stim[2*added+1]));
            added++;
         end
         if (bus.out_valid) begin
            chk_i("in_ready_in_out", int'(bus.in_ready), 0);
            chk_v("out_data", bus.out_data, exp_q[res]);
            chk_i("out_last", int'(bus.out_last), int'(res == n - 1));
            if (prev_stall) chk_v("stall_hold", bus.out_data, held);
            if (first_ov < 0) first_ov = cyc;
            if (!prev_ov) begin
               if (timing && last_rise >= 0) chk_i("pair_period", cyc - last_rise, 4 + ADD_LAT);
               last_rise = cyc;
            end
            if (res == stall_pair && stall_left > 0) begin
               bus.out_ready = 1'b0;
               stall_left--;
            end else begin
               bus.out_ready = 1'b1;
            end
            held = bus.out_data;
         end else begin
            bus.out_ready = 1'($urandom);
         end
         prev_ov    = bus.out_valid;
         prev_stall = bus.out_valid && !bus.out_ready;
         bus.in_valid = toggle_in ? cyc[0] : 1'b1;
         bus.in_data  = (bus.in_valid && idx < 2*n) ? stim[idx]
                                                    : VEC_W'({$urandom, $urandom, $urandom});
         hs    = bus.in_ready && bus.in_valid;
         ov_hs = bus.out_valid && bus.out_ready;
         if (ov_hs) last_out = bus.out_data;
         @(posedge clk);
         if (hs) begin
            if (first_hs < 0) first_hs = cyc;
            idx++;
         end
         if (ov_hs) res++;
         #1;
         cyc++;
      end
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      chk_i("results_count", res, n);
      chk_i("inputs_taken", idx, 2*n);
      chk_i("done_pulse", int'(bus.done), 1);
      chk_i("busy_at_done", int'(bus.busy), 0);
      chk_i("enable_pulses", n_enable - en0, n);
      if (timing) chk_i("first_latency", first_ov - first_hs, 3 + ADD_LAT);
      tick();
      chk_i("done_one_cycle", int'(bus.done), 0);
   endtask

   initial begin
      int n, guard;
      reset = 1'b0;
      bus.start = 1'b0; bus.num_pairs = '0; bus.in_valid = 1'b0;
      bus.in_data = '0; bus.out_ready = 1'b0;

      // Reset held for three cycles under random inputs.
      for (int i = 0; i < 3; i++) begin
         bus.start     = 1'($urandom);
         bus.num_pairs = 8'($urandom);
         bus.in_valid  = 1'($urandom);
         bus.in_data   = VEC_W'({$urandom, $urandom, $urandom});
         bus.out_ready = 1'($urandom);
         tick();
         chk_i("reset_flags", int'({bus.busy, bus.done, bus.in_ready, bus.add_enable,
                                    bus.out_valid, bus.out_last}), 0);
         chk_v("reset_num_1", SUM_W'(bus.add_num_1), '0);
         chk_v("reset_num_2", SUM_W'(bus.add_num_2), '0);
         chk_v("reset_out_data", bus.out_data, '0);
      end
      bus.start = 1'b0; bus.in_valid = 1'b0;
      reset = 1'b1;
      tick();
      chk_i("busy_after_reset", int'(bus.busy), 0);

      // Single pair with known lanes.
      stim = {mk_vec(1, 2, 3, 4), mk_vec(10, 20, 30, 40)};
      run_job(1, 1'b0, -1, 0, 1'b0);
      chk_v("single_sum", last_out, {18'd44, 18'd33, 18'd22, 18'd11});

      // Full-scale lanes: carry must stay inside each lane.
      stim = {mk_vec('h1FFFF, 'h1FFFF, 'h1FFFF, 'h1FFFF),
              mk_vec('h1FFFF, 'h1FFFF, 'h1FFFF, 'h1FFFF)};
      run_job(1, 1'b0, -1, 0, 1'b0);
      chk_v("width_growth", last_out, {4{18'h3FFFE}});

      // Backpressure: toggling input valid, 5-cycle output stall on pair 2.
      stim.delete();
      for (int i = 0; i < 6; i++) stim.push_back(VEC_W'({$urandom, $urandom, $urandom}));
      run_job(3, 1'b1, 1, 5, 1'b0);

      // Stall-free multi-pair job with a start pulse injected while busy.
      stim.delete();
      for (int i = 0; i < 6; i++) stim.push_back(VEC_W'({$urandom, $urandom, $urandom}));
      run_job(3, 1'b0, -1, 0, 1'b1);

      // Zero-length job.
      bus.start = 1'b1; bus.num_pairs = 8'd0;
      tick();
      bus.start = 1'b0;
      chk_i("zero_done", int'(bus.done), 1);
      chk_i("zero_busy", int'(bus.busy), 0);
      chk_i("zero_in_ready", int'(bus.in_ready), 0);
      tick();
      chk_i("zero_done_clear", int'(bus.done), 0);
      chk_i("zero_busy_after", int'(bus.busy), 0);

      // Reset during WAIT of pair 2 of 4.
      stim.delete();
      for (int i = 0; i < 8; i++) stim.push_back(VEC_W'({$urandom, $urandom, $urandom}));
      n = n_enable;
      bus.start = 1'b1; bus.num_pairs = 8'd4;
      tick();
      bus.start = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      guard = 0;
      while (!(n_enable - n == 2 && !bus.add_enable) && guard < 100) begin
         bus.in_data = stim[0];
         tick();
         guard++;
      end
      chk_i("reach_wait2", int'(guard < 100), 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk_i("midreset_busy", int'(bus.busy), 0);
      for (int i = 0; i < 8; i++) begin
         chk_i("midreset_no_valid", int'(bus.out_valid), 0);
         chk_i("midreset_no_done", int'(bus.done), 0);
         tick();
      end
      bus.in_valid = 1'b0;
      stim = {mk_vec(5, 6, 7, 8), mk_vec(100, 200, 300, 400)};
      run_job(1, 1'b0, -1, 0, 1'b0);
      chk_v("after_reset_sum", last_out, {18'd408, 18'd307, 18'd206, 18'd105});

      // Randomised jobs.
      for (int j = 0; j < 4; j++) begin
         n = $urandom_range(1, 4);
         stim.delete();
         for (int i = 0; i < 2*n; i++) stim.push_back(VEC_W'({$urandom, $urandom, $urandom}));
         run_job(n, 1'($urandom), $urandom_range(0, n - 1), $urandom_range(0, 3), 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
